// File: rtl/mux_select_unit.sv
// Selector bank sharing one select bus: a bit mux, a 2-way word mux and a
// 4-way word mux, each with a combinational output and a registered copy.
module mux_select_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       sel,
   input  logic             bit_a,
   input  logic             bit_b,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic             mux0,
   output logic [WIDTH-1:0] mux2,
   output logic [WIDTH-1:0] mux4,
   output logic             mux0_q,
   output logic [WIDTH-1:0] mux2_q,
   output logic [WIDTH-1:0] mux4_q
);

   // Word mux as the AND/OR gate equation replicated across every bit.
   function automatic logic [WIDTH-1:0] word_mux(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             s);
      return (x & ~{WIDTH{s}}) | (y & {WIDTH{s}});
   endfunction

   logic [WIDTH-1:0] low_pair;
   logic [WIDTH-1:0] high_pair;

   // The 4-way mux is a tree: first level on sel[0], final level on sel[1].
   always_comb begin
      mux0      = (bit_a & ~sel[2]) | (bit_b & sel[2]);
      mux2      = word_mux(a, b, sel[0]);
      low_pair  = word_mux(a, b, sel[0]);
      high_pair = word_mux(c, d, sel[0]);
      mux4      = word_mux(low_pair, high_pair, sel[1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mux0_q <= 1'b0;
         mux2_q <= '0;
         mux4_q <= '0;
      end else begin
         mux0_q <= mux0;
         mux2_q <= mux2;
         mux4_q <= mux4;
      end
   end

endmodule

// File: tb/tb_mux_select_unit.sv
// Randomised and directed bench for mux_select_unit; expected responses are
// queued by the stimulus side and checked by an independent monitor.
module tb_mux_select_unit;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic [2:0]       sel;
   logic             bit_a;
   logic             bit_b;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             mux0;
   logic [WIDTH-1:0] mux2;
   logic [WIDTH-1:0] mux4;
   logic             mux0_q;
   logic [WIDTH-1:0] mux2_q;
   logic [WIDTH-1:0] mux4_q;

   typedef struct {
      logic             m0;
      logic [WIDTH-1:0] m2;
      logic [WIDTH-1:0] m4;
      logic             m0q;
      logic [WIDTH-1:0] m2q;
      logic [WIDTH-1:0] m4q;
   } expect_t;

   expect_t expQ[$];
   int      nVectors = 0;
   int      nMiscompares = 0;
   bit      stimDone = 0;

   mux_select_unit #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .sel    (sel),
      .bit_a  (bit_a),
      .bit_b  (bit_b),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .mux0   (mux0),
      .mux2   (mux2),
      .mux4   (mux4),
      .mux0_q (mux0_q),
      .mux2_q (mux2_q),
      .mux4_q (mux4_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: pick the word by index, as a table lookup.
   task automatic applyStimulus(input logic r, input logic [2:0] s, input logic ba,
                                input logic bb, input logic [WIDTH-1:0] wa,
                                input logic [WIDTH-1:0] wb, input logic [WIDTH-1:0] wc,
                                input logic [WIDTH-1:0] wd);
      logic [WIDTH-1:0] words[4];
      expect_t e;
      @(negedge clk);
      rst = r; sel = s; bit_a = ba; bit_b = bb; a = wa; b = wb; c = wc; d = wd;
      words[0] = wa; words[1] = wb; words[2] = wc; words[3] = wd;
      e.m0  = (s >= 3'd4) ? bb : ba;
      e.m2  = (s % 2 == 1) ? wb : wa;
      e.m4  = words[s % 4];
      e.m0q = r ? 1'b0 : e.m0;
      e.m2q = r ? '0 : e.m2;
      e.m4q = r ? '0 : e.m4;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   // Monitor: shortly after each rising edge, compare against the oldest expectation.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("mux0",   {{(WIDTH-1){1'b0}}, mux0},   {{(WIDTH-1){1'b0}}, e.m0});
            checkOutput("mux2",   mux2,   e.m2);
            checkOutput("mux4",   mux4,   e.m4);
            checkOutput("mux0_q", {{(WIDTH-1){1'b0}}, mux0_q}, {{(WIDTH-1){1'b0}}, e.m0q});
            checkOutput("mux2_q", mux2_q, e.m2q);
            checkOutput("mux4_q", mux4_q, e.m4q);
         end
      end
   end

   initial begin
      int waitCycles;
      rst = 1'b1; sel = '0; bit_a = 1'b0; bit_b = 1'b0;
      a = '0; b = '0; c = '0; d = '0;

      // Reset held over two edges with varied data.
      applyStimulus(1'b1, 3'd7, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);

      // Sweep sel twice so the 7->0 wrap is exercised.
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b0, 3'(i), 1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);

      applyStimulus(1'b0, 3'b101, 1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
      applyStimulus(1'b0, 3'd2,   1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
      applyStimulus(1'b0, 3'd7,   1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
      applyStimulus(1'b1, 3'd7,   1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
      applyStimulus(1'b1, 3'd7,   1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
      applyStimulus(1'b0, 3'd7,   1'b0, 1'b1, 16'h0000, 16'h1111, 16'h2222, 16'h3333);

      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 3'(i), 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555);

      for (int i = 0; i < 300; i++)
         applyStimulus(($urandom_range(15) == 0), 3'($urandom_range(7)),
                       1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                       16'($urandom), 16'($urandom));

      stimDone = 1'b1;
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      #2;
      if (expQ.size() > 0) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
